// File: rtl/iob_native_pkg.sv
// rtl/iob_native_pkg.sv - iob native bus field layout, widths and responder FSM encoding
package iob_native_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // req = {valid, addr, wdata, wstrb}; resp = {rdata, ready}
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int wstrb_lsb();
        return 0;
    endfunction

    function automatic int wdata_lsb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int valid_bit(input int addr_w, input int data_w);
        return req_width(addr_w, data_w) - 1;
    endfunction

    localparam int READY_BIT = 0;
    localparam int RDATA_LSB = 1;

    localparam int DEF_REQ_W  = 1 + DEF_ADDR_W + DEF_DATA_W + DEF_DATA_W / 8;
    localparam int DEF_RESP_W = DEF_DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } iob_state_e;

endpackage

// File: rtl/iob_ram_sp_be.sv
// rtl/iob_ram_sp_be.sv - single-port RAM with byte-lane write enables and registered read port
module iob_ram_sp_be #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

    // rdata only moves on a read access, so it holds the last read word
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            if (we == '0) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/iob_mem_responder.sv
// rtl/iob_mem_responder.sv - iob native-bus target: SRAM with wait states and overrun flag
module iob_mem_responder
    import iob_native_pkg::*;
#(
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int MEM_ADDR_W  = 10,
    parameter  int WAIT_CYCLES = 1,
    localparam int REQ_W       = req_width(ADDR_W, DATA_W),
    localparam int RESP_W      = resp_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  req,
    output logic [RESP_W-1:0] resp,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    iob_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_read_q;
    logic              ready;
    logic              accept;
    logic              valid;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_addr_bits;

    assign valid = req[valid_bit(ADDR_W, DATA_W)];
    assign wstrb = req[wstrb_lsb() +: STRB_W];
    assign wdata = req[wdata_lsb(DATA_W) +: DATA_W];
    // Byte offset and bits above the RAM window belong to the interconnect decode
    assign unused_addr_bits = ^req[addr_lsb(DATA_W) +: ADDR_W];

    // A request in WAIT is dropped without touching the RAM
    assign accept = rst && valid && (state_q == ST_IDLE || state_q == ST_RESP);

    iob_ram_sp_be #(
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (accept),
        .we    (wstrb & {STRB_W{accept}}),
        .addr  (req[addr_lsb(DATA_W) + 2 +: MEM_ADDR_W]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            is_read_q <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                is_read_q <= (wstrb == '0);
            end
            if (valid && state_q == ST_WAIT) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                ready = 1'b1;
                if (valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign resp[READY_BIT]               = ready;
    assign resp[RDATA_LSB +: DATA_W]     = (ready && is_read_q) ? ram_rdata : '0;

endmodule
